// File: rtl/phased_tag_lookup.sv
// rtl/phased_tag_lookup.sv - phased cache read controller: tag compare, then single-way data read
// One lookup in flight: IDLE -> TAG -> (DATA on hit) -> RESP, with saturating hit/miss counters.
module phased_tag_lookup #(
   parameter int TAG_W  = 26,
   parameter int IDX_W  = 3,
   parameter int OFF_W  = 3,
   parameter int WAYS   = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [TAG_W+IDX_W+OFF_W-1:0] req_addr,
   output logic [IDX_W-1:0]          tag_rd_idx,
   input  logic [WAYS*TAG_W-1:0]     tag_rd_tags,
   input  logic [WAYS-1:0]           tag_rd_valid,
   output logic [WAYS-1:0]           data_rd_en,
   output logic [IDX_W-1:0]          data_rd_idx,
   output logic [OFF_W-1:0]          data_rd_off,
   input  logic [DATA_W-1:0]         data_rd_data,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic                      resp_hit,
   output logic [1:0]                resp_way,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_multihit,
   output logic [CNT_W-1:0]          hit_count,
   output logic [CNT_W-1:0]          miss_count
);

   localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
   localparam int MC_W   = $clog2(WAYS + 1);

   typedef enum logic [1:0] {S_IDLE, S_TAG, S_DATA, S_RESP} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [IDX_W-1:0]    tag_idx_q, tag_idx_d;
   logic                resp_hit_q, resp_hit_d;
   logic [1:0]          resp_way_q, resp_way_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                multihit_q, multihit_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

   logic [TAG_W-1:0]    lat_tag;
   logic [WAYS-1:0]     match;
   logic [1:0]          first_way;
   logic [MC_W-1:0]     match_cnt;

   assign lat_tag = addr_q[ADDR_W-1 -: TAG_W];

   // Descending scan so the lowest matching way wins.
   always_comb begin
      match     = '0;
      first_way = '0;
      match_cnt = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         match[w] = tag_rd_valid[w] & (tag_rd_tags[w*TAG_W +: TAG_W] == lat_tag);
         if (match[w]) begin
            first_way = w[1:0];
            match_cnt = match_cnt + MC_W'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      tag_idx_d   = tag_idx_q;
      resp_hit_d  = resp_hit_q;
      resp_way_d  = resp_way_q;
      resp_data_d = resp_data_q;
      multihit_d  = multihit_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      data_rd_en  = '0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               addr_d    = req_addr;
               tag_idx_d = req_addr[OFF_W +: IDX_W];
               state_d   = S_TAG;
            end
         end
         S_TAG: begin
            if (|match) begin
               resp_way_d = first_way;
               multihit_d = (match_cnt > MC_W'(1));
               state_d    = S_DATA;
            end else begin
               resp_hit_d  = 1'b0;
               resp_way_d  = '0;
               resp_data_d = '0;
               multihit_d  = 1'b0;
               if (miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt_q + CNT_W'(1);
               state_d = S_RESP;
            end
         end
         S_DATA: begin
            data_rd_en[resp_way_q] = 1'b1;
            resp_data_d = data_rd_data;
            resp_hit_d  = 1'b1;
            if (hit_cnt_q != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt_q + CNT_W'(1);
            state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               multihit_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         tag_idx_q   <= '0;
         resp_hit_q  <= 1'b0;
         resp_way_q  <= '0;
         resp_data_q <= '0;
         multihit_q  <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         tag_idx_q   <= tag_idx_d;
         resp_hit_q  <= resp_hit_d;
         resp_way_q  <= resp_way_d;
         resp_data_q <= resp_data_d;
         multihit_q  <= multihit_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
      end
   end

   assign tag_rd_idx    = tag_idx_q;
   assign data_rd_idx   = addr_q[OFF_W +: IDX_W];
   assign data_rd_off   = addr_q[OFF_W-1:0];
   assign resp_hit      = resp_hit_q;
   assign resp_way      = resp_way_q;
   assign resp_data     = resp_data_q;
   assign resp_multihit = multihit_q;
   assign hit_count     = hit_cnt_q;
   assign miss_count    = miss_cnt_q;

endmodule

// File: tb/tb_phased_tag_lookup.sv
// tb/tb_phased_tag_lookup.sv - randomized bench for phased_tag_lookup with array/counter reference model
module tb_phased_tag_lookup;

   localparam int TAG_W  = 26;
   localparam int IDX_W  = 3;
   localparam int OFF_W  = 3;
   localparam int WAYS   = 4;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;
   localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_W-1:0]     req_addr;
   logic [IDX_W-1:0]      tag_rd_idx;
   logic [WAYS*TAG_W-1:0] tag_rd_tags;
   logic [WAYS-1:0]       tag_rd_valid;
   logic [WAYS-1:0]       data_rd_en;
   logic [IDX_W-1:0]      data_rd_idx;
   logic [OFF_W-1:0]      data_rd_off;
   logic [DATA_W-1:0]     data_rd_data;
   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_hit;
   logic [1:0]            resp_way;
   logic [DATA_W-1:0]     resp_data;
   logic                  resp_multihit;
   logic [CNT_W-1:0]      hit_count;
   logic [CNT_W-1:0]      miss_count;

   logic [TAG_W-1:0]  tag_mem  [8][4];
   logic              vld_mem  [8][4];
   logic [DATA_W-1:0] data_mem [8][4][8];
   logic [TAG_W-1:0]  pool     [4];

   int tests = 0;
   int fails = 0;
   int exp_hits = 0;
   int exp_miss = 0;

   phased_tag_lookup #(
      .TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W),
      .WAYS(WAYS), .DATA_W(DATA_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .tag_rd_idx(tag_rd_idx), .tag_rd_tags(tag_rd_tags), .tag_rd_valid(tag_rd_valid),
      .data_rd_en(data_rd_en), .data_rd_idx(data_rd_idx), .data_rd_off(data_rd_off),
      .data_rd_data(data_rd_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
      .resp_way(resp_way), .resp_data(resp_data), .resp_multihit(resp_multihit),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   // Storage arrays: tag read combinational from tag_rd_idx, data from the enabled way.
   always_comb begin
      tag_rd_tags  = '0;
      tag_rd_valid = '0;
      for (int w = 0; w < WAYS; w++) begin
         tag_rd_tags[w*TAG_W +: TAG_W] = tag_mem[tag_rd_idx][w];
         tag_rd_valid[w]               = vld_mem[tag_rd_idx][w];
      end
   end

   always_comb begin
      data_rd_data = '0;
      for (int w = 0; w < WAYS; w++)
         if (data_rd_en[w]) data_rd_data = data_rd_data | data_mem[data_rd_idx][w][data_rd_off];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_arrays();
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 4; w++) begin
            tag_mem[s][w] = '0;
            vld_mem[s][w] = 1'b0;
            for (int o = 0; o < 8; o++) data_mem[s][w][o] = $urandom;
         end
   endtask

   task automatic randomize_arrays();
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 4; w++) begin
            tag_mem[s][w] = pool[$urandom_range(0, 3)];
            vld_mem[s][w] = ($urandom_range(0, 2) != 0);
            for (int o = 0; o < 8; o++) data_mem[s][w][o] = $urandom;
         end
   endtask

   task automatic run_req(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                          input logic [OFF_W-1:0] off, input int stall);
      int n = 0;
      int nm = 0;
      int fw = 0;
      logic [DATA_W-1:0] exp_data;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_idle", req_ready, 1);
      for (int w = 0; w < 4; w++)
         if (vld_mem[idx][w] && tag_mem[idx][w] == tag) begin
            if (nm == 0) fw = w;
            nm++;
         end
      exp_data = (nm > 0) ? data_mem[idx][fw][off] : '0;
      req_valid  = 1'b1;
      req_addr   = {tag, idx, off};
      resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = ADDR_W'($urandom);
      check("tag_idx", tag_rd_idx, idx);
      check("tag_no_en", data_rd_en, 0);
      check("tag_no_resp", resp_valid, 0);
      check("tag_busy", req_ready, 0);
      @(negedge clk);
      if (nm > 0) begin
         check("data_en", data_rd_en, 64'd1 << fw);
         check("data_idx", data_rd_idx, idx);
         check("data_off", data_rd_off, off);
         check("data_no_resp", resp_valid, 0);
         if (exp_hits < CMAX) exp_hits++;
         @(negedge clk);
      end else begin
         if (exp_miss < CMAX) exp_miss++;
      end
      check("resp_valid", resp_valid, 1);
      check("resp_en_off", data_rd_en, 0);
      check("resp_hit", resp_hit, (nm > 0) ? 1 : 0);
      check("resp_way", resp_way, fw);
      check("resp_data", resp_data, exp_data);
      check("resp_multihit", resp_multihit, (nm > 1) ? 1 : 0);
      check("hit_count", hit_count, exp_hits);
      check("miss_count", miss_count, exp_miss);
      for (int i = 0; i < stall; i++) begin
         req_valid = 1'b1;
         req_addr  = ADDR_W'($urandom);
         @(negedge clk);
         check("stall_ready", req_ready, 0);
         check("stall_valid", resp_valid, 1);
         check("stall_way", resp_way, fw);
         check("stall_data", resp_data, exp_data);
         check("stall_hits", hit_count, exp_hits);
         check("stall_miss", miss_count, exp_miss);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("post_valid", resp_valid, 0);
      check("post_ready", req_ready, 1);
      check("post_multihit", resp_multihit, 0);
   endtask

   initial begin
      logic [TAG_W-1:0] t;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_addr   = '0;
      resp_ready = 1'b0;
      pool[0] = 26'h2ABCDEF; pool[1] = 26'h0000001;
      pool[2] = 26'h3FFFFFF; pool[3] = 26'h1234567;
      clear_arrays();
      repeat (3) @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_valid", resp_valid, 0);
      check("rst_en", data_rd_en, 0);
      check("rst_hits", hit_count, 0);
      check("rst_miss", miss_count, 0);
      check("rst_idx", tag_rd_idx, 0);
      check("rst_multihit", resp_multihit, 0);
      reset = 1'b0;
      @(negedge clk);

      tag_mem[5][2] = 26'h2ABCDEF; vld_mem[5][2] = 1'b1;
      run_req(26'h2ABCDEF, 3'd5, 3'd1, 0);
      vld_mem[5][2] = 1'b0;
      run_req(26'h2ABCDEF, 3'd5, 3'd1, 0);
      tag_mem[5][1] = 26'h2ABCDEF; vld_mem[5][1] = 1'b1;
      tag_mem[5][3] = 26'h2ABCDEF; vld_mem[5][3] = 1'b1;
      run_req(26'h2ABCDEF, 3'd5, 3'd6, 0);
      run_req(26'h2ABCDEF, 3'd5, 3'd7, 5);

      // Abandon a hit while its data-array read is in progress.
      req_valid = 1'b1;
      req_addr  = {26'h2ABCDEF, 3'd5, 3'd2};
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_en", data_rd_en, 4'b0010);
      reset = 1'b1;
      @(negedge clk);
      check("mid_ready", req_ready, 1);
      check("mid_valid", resp_valid, 0);
      check("mid_en_off", data_rd_en, 0);
      check("mid_hits", hit_count, 0);
      check("mid_miss", miss_count, 0);
      reset = 1'b0;
      exp_hits = 0;
      exp_miss = 0;
      @(negedge clk);

      for (int i = 0; i < 200; i++) begin
         if (i % 8 == 0) randomize_arrays();
         t = ($urandom_range(0, 4) == 0) ? TAG_W'($urandom) : pool[$urandom_range(0, 3)];
         run_req(t, IDX_W'($urandom), OFF_W'($urandom), $urandom_range(0, 3));
      end

      for (int s = 0; s < 8; s++) begin
         tag_mem[s][0] = 26'h0ABCDE;
         vld_mem[s][0] = 1'b1;
      end
      for (int i = 0; i < CMAX + 2; i++)
         run_req(26'h0ABCDE, IDX_W'($urandom), OFF_W'($urandom), 0);
      check("hit_saturated", hit_count, CMAX);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
